// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle ARM controller and its datapath.
// The controller takes the master view; the datapath takes the slave view.
interface multicycle_controller_if #(
  parameter int CNT_WIDTH = 16
);
  logic [31:0]          Instr;
  logic [3:0]           ALUFlags;
  logic                 PCWrite, AdrSrc, MemWrite, IRWrite, CarryIN;
  logic                 SetFlags, Shift_ctrl, ALUSrcA, RegWrite;
  logic [1:0]           ResultSrc, ALUSrcB, ImmSrc, RegSrc, BL_ctrl;
  logic [3:0]           ALUControl;
  logic [3:0]           state;
  logic                 instr_done, illegal;
  logic [CNT_WIDTH-1:0] retired;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, CarryIN, SetFlags, Shift_ctrl,
           ALUSrcA, RegWrite, ResultSrc, ALUSrcB, ImmSrc, RegSrc, BL_ctrl,
           ALUControl, state, instr_done, illegal, retired
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, CarryIN, SetFlags, Shift_ctrl,
           ALUSrcA, RegWrite, ResultSrc, ALUSrcB, ImmSrc, RegSrc, BL_ctrl,
           ALUControl, state, instr_done, illegal, retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore-style main FSM and combinational decode for the multi-cycle ARM datapath,
// with a retired-instruction counter for debug.
module multicycle_controller #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_e;

  typedef struct packed {
    logic       pcWrite, adrSrc, memWrite, irWrite, carryIn;
    logic       setFlags, shiftCtrl, aluSrcA, regWrite;
    logic [1:0] resultSrc, aluSrcB, immSrc, regSrc, blCtrl;
    logic [3:0] aluControl;
    logic       instrDone, illegal;
  } ctl_t;

  state_e               state_q;
  logic                 condLatch_q;
  logic [CNT_WIDTH-1:0] retired_q;

  logic [3:0] cond, cmd;
  logic [1:0] op;
  logic       immBit, sBit, loadBit, upBit, linkBit, rdIsPc;
  logic       flagZ, flagN, flagC, flagV;
  logic       condEx, isTest, isIllegal, isStr, usesCarry;
  logic       unusedInstrBits;
  ctl_t       ctlRaw, ctl;

  assign cond    = bus.Instr[31:28];
  assign op      = bus.Instr[27:26];
  assign immBit  = bus.Instr[25];
  assign linkBit = bus.Instr[24];
  assign cmd     = bus.Instr[24:21];
  assign upBit   = bus.Instr[23];
  assign sBit    = bus.Instr[20];
  assign loadBit = bus.Instr[20];
  assign rdIsPc  = (bus.Instr[15:12] == 4'hF);
  assign unusedInstrBits = ^{bus.Instr[22], bus.Instr[19:16], bus.Instr[11:0]};

  assign {flagZ, flagN, flagC, flagV} = bus.ALUFlags;

  assign isTest    = (cmd[3:2] == 2'b10);
  assign isStr     = (op == 2'b01) && !loadBit;
  assign usesCarry = (cmd == 4'b0101) || (cmd == 4'b0110) || (cmd == 4'b0111);
  assign isIllegal = (cond == 4'b1111) || (op == 2'b11) || ((op == 2'b01) && immBit);

  always_comb begin
    condEx = 1'b0;
    case (cond)
      4'b0000: condEx = flagZ;
      4'b0001: condEx = !flagZ;
      4'b0010: condEx = flagC;
      4'b0011: condEx = !flagC;
      4'b0100: condEx = flagN;
      4'b0101: condEx = !flagN;
      4'b0110: condEx = flagV;
      4'b0111: condEx = !flagV;
      4'b1000: condEx = flagC && !flagZ;
      4'b1001: condEx = !flagC || flagZ;
      4'b1010: condEx = (flagN == flagV);
      4'b1011: condEx = (flagN != flagV);
      4'b1100: condEx = !flagZ && (flagN == flagV);
      4'b1101: condEx = flagZ || (flagN != flagV);
      4'b1110: condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end

  // The condition is captured while executing so that ALUWB ignores the flags
  // this same instruction may have just written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FETCH;
      condLatch_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      case (state_q)
        FETCH:  state_q <= DECODE;
        DECODE: begin
          if (isIllegal)         state_q <= FETCH;
          else if (op == 2'b01)  state_q <= MEMADR;
          else if (op == 2'b00)  state_q <= immBit ? EXECI : EXECR;
          else                   state_q <= BRANCH;
        end
        MEMADR: state_q <= loadBit ? MEMRD : MEMWR;
        MEMRD:  state_q <= MEMWB;
        EXECR, EXECI: begin
          state_q     <= ALUWB;
          condLatch_q <= condEx;
        end
        default: state_q <= FETCH;
      endcase
      if (ctlRaw.instrDone) retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    ctlRaw        = '0;
    ctlRaw.immSrc = (op == 2'b11) ? 2'b00 : op;
    ctlRaw.regSrc = {isStr, (op == 2'b10)};
    case (state_q)
      FETCH: begin
        ctlRaw.irWrite    = 1'b1;
        ctlRaw.pcWrite    = 1'b1;
        ctlRaw.aluSrcA    = 1'b1;
        ctlRaw.aluSrcB    = 2'b10;
        ctlRaw.aluControl = 4'b0100;
        ctlRaw.resultSrc  = 2'b10;
      end
      DECODE: begin
        ctlRaw.aluSrcA    = 1'b1;
        ctlRaw.aluSrcB    = 2'b10;
        ctlRaw.aluControl = 4'b0100;
        ctlRaw.resultSrc  = 2'b10;
        ctlRaw.illegal    = isIllegal;
      end
      MEMADR: begin
        ctlRaw.aluSrcB    = 2'b01;
        ctlRaw.aluControl = upBit ? 4'b0100 : 4'b0010;
      end
      MEMRD: ctlRaw.adrSrc = 1'b1;
      MEMWB: begin
        ctlRaw.resultSrc = 2'b01;
        ctlRaw.regWrite  = condEx;
        ctlRaw.instrDone = 1'b1;
      end
      MEMWR: begin
        ctlRaw.adrSrc    = 1'b1;
        ctlRaw.memWrite  = condEx;
        ctlRaw.instrDone = 1'b1;
      end
      EXECR, EXECI: begin
        ctlRaw.aluSrcB    = 2'b11;
        ctlRaw.shiftCtrl  = (state_q == EXECI);
        ctlRaw.aluControl = cmd;
        ctlRaw.setFlags   = condEx && (sBit || isTest);
        ctlRaw.carryIn    = usesCarry && flagC;
      end
      ALUWB: begin
        ctlRaw.regWrite  = condLatch_q && !isTest;
        ctlRaw.pcWrite   = condLatch_q && rdIsPc;
        ctlRaw.instrDone = 1'b1;
      end
      BRANCH: begin
        ctlRaw.aluSrcB    = 2'b01;
        ctlRaw.aluControl = 4'b0100;
        ctlRaw.resultSrc  = 2'b10;
        ctlRaw.pcWrite    = condEx;
        ctlRaw.regWrite   = condEx && linkBit;
        ctlRaw.blCtrl     = linkBit ? 2'b11 : 2'b00;
        ctlRaw.instrDone  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset blanks every output at once, so an aborted instruction issues no write.
  assign ctl = reset ? '0 : ctlRaw;

  assign bus.PCWrite    = ctl.pcWrite;
  assign bus.AdrSrc     = ctl.adrSrc;
  assign bus.MemWrite   = ctl.memWrite;
  assign bus.IRWrite    = ctl.irWrite;
  assign bus.CarryIN    = ctl.carryIn;
  assign bus.SetFlags   = ctl.setFlags;
  assign bus.Shift_ctrl = ctl.shiftCtrl;
  assign bus.ALUSrcA    = ctl.aluSrcA;
  assign bus.RegWrite   = ctl.regWrite;
  assign bus.ResultSrc  = ctl.resultSrc;
  assign bus.ALUSrcB    = ctl.aluSrcB;
  assign bus.ImmSrc     = ctl.immSrc;
  assign bus.RegSrc     = ctl.regSrc;
  assign bus.BL_ctrl    = ctl.blCtrl;
  assign bus.ALUControl = ctl.aluControl;
  assign bus.instr_done = ctl.instrDone;
  assign bus.illegal    = ctl.illegal;
  assign bus.state      = reset ? 4'd0 : state_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control words are
// queued per instruction and compared cycle by cycle against the DUT.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcw, adrs, memw, irw, cin, setf, shf, srca, regw;
    logic [1:0] ress, srcb, imms, regs, bl;
    logic [3:0] aluc;
    logic [3:0] st;
    logic       done, ill;
  } ctl_t;

  typedef struct {
    string      tag;
    logic [3:0] flags;
    ctl_t       exp;
  } rec_t;

  logic       clk;
  logic       reset;
  rec_t       sb[$];
  int         nChecks;
  int         nFail;
  logic [15:0] expRetired;

  multicycle_controller_if #(.CNT_WIDTH(16)) bus ();
  multicycle_controller_if #(.CNT_WIDTH(3))  wbus ();

  multicycle_controller #(.CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  multicycle_controller #(.CNT_WIDTH(3)) dutWrap (
    .clk   (clk),
    .reset (reset),
    .bus   (wbus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference for one cycle's outputs, given the state the test expects to be in.
  function automatic ctl_t model(logic [3:0] st, logic [31:0] ins, bit pass, bit carry);
    ctl_t c;
    logic [1:0] cls;
    logic [3:0] opc;
    bit testOp;
    c = '0;
    cls = ins[27:26];
    opc = ins[24:21];
    testOp = (opc >= 4'd8) && (opc <= 4'd11);
    c.st = st;
    case (cls)
      2'b00:   c.imms = 2'b00;
      2'b01:   c.imms = 2'b01;
      2'b10:   c.imms = 2'b10;
      default: c.imms = 2'b00;
    endcase
    c.regs[1] = (cls == 2'b01) && !ins[20];
    c.regs[0] = (cls == 2'b10);
    case (st)
      4'd0: begin c.irw = 1; c.pcw = 1; c.srca = 1; c.srcb = 2; c.aluc = 4; c.ress = 2; end
      4'd1: begin
        c.srca = 1; c.srcb = 2; c.aluc = 4; c.ress = 2;
        c.ill = (ins[31:28] == 4'hF) || (cls == 2'b11) || (cls == 2'b01 && ins[25]);
      end
      4'd2: begin c.srcb = 1; c.aluc = ins[23] ? 4'd4 : 4'd2; end
      4'd3: c.adrs = 1;
      4'd4: begin c.ress = 1; c.regw = pass; c.done = 1; end
      4'd5: begin c.adrs = 1; c.memw = pass; c.done = 1; end
      4'd6, 4'd7: begin
        c.srcb = 3; c.shf = (st == 4'd7); c.aluc = opc;
        c.setf = pass && (ins[20] || testOp);
        c.cin = carry && (opc == 4'd5 || opc == 4'd6 || opc == 4'd7);
      end
      4'd8: begin
        c.regw = pass && !testOp; c.pcw = pass && (ins[15:12] == 4'hF); c.done = 1;
      end
      4'd9: begin
        c.srcb = 1; c.aluc = 4; c.ress = 2; c.pcw = pass;
        c.regw = pass && ins[24]; c.bl = ins[24] ? 2'b11 : 2'b00; c.done = 1;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctl_t sample();
    ctl_t s;
    s.pcw = bus.PCWrite;   s.adrs = bus.AdrSrc;     s.memw = bus.MemWrite;
    s.irw = bus.IRWrite;   s.cin = bus.CarryIN;     s.setf = bus.SetFlags;
    s.shf = bus.Shift_ctrl; s.srca = bus.ALUSrcA;   s.regw = bus.RegWrite;
    s.ress = bus.ResultSrc; s.srcb = bus.ALUSrcB;   s.imms = bus.ImmSrc;
    s.regs = bus.RegSrc;   s.bl = bus.BL_ctrl;      s.aluc = bus.ALUControl;
    s.st = bus.state;      s.done = bus.instr_done; s.ill = bus.illegal;
    return s;
  endfunction

  task automatic driveFlags(input logic [3:0] f);
    bus.ALUFlags  = f;
    wbus.ALUFlags = f;
  endtask

  // seq holds the expected state path as nibbles, first state most significant.
  task automatic applyStimulus(input string tag, input logic [31:0] ins, input logic [3:0] flags,
                               input bit pass, input int n, input logic [31:0] seq,
                               input int lateIdx, input logic [3:0] lateFlags);
    rec_t r;
    logic [3:0] st;
    logic [3:0] f;
    bus.Instr  = ins;
    wbus.Instr = ins;
    for (int i = 0; i < n; i++) begin
      st = seq[4*(n-1-i) +: 4];
      f = (i >= lateIdx) ? lateFlags : flags;
      r.tag = $sformatf("%s.s%0d", tag, st);
      r.flags = f;
      r.exp = model(st, ins, pass, f[1]);
      sb.push_back(r);
    end
  endtask

  task automatic checkOutput();
    rec_t r;
    ctl_t got;
    int i;
    i = 0;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      if (i > 0) @(negedge clk);
      driveFlags(r.flags);
      #1;
      got = sample();
      nChecks++;
      assert (got === r.exp) else begin
        nFail++;
        $error("[TB] FAIL %s got=%h expected=%h", r.tag, got, r.exp);
      end
      i++;
    end
  endtask

  task automatic checkRetired(input string tag);
    logic [2:0] expWrap;
    expWrap = expRetired[2:0];
    nChecks++;
    assert (bus.retired === expRetired) else begin
      nFail++;
      $error("[TB] FAIL %s.retired got=%h expected=%h", tag, bus.retired, expRetired);
    end
    nChecks++;
    assert (wbus.retired === expWrap) else begin
      nFail++;
      $error("[TB] FAIL %s.retiredWrap got=%h expected=%h", tag, wbus.retired, expWrap);
    end
  endtask

  task automatic runInstr(input string tag, input logic [31:0] ins, input logic [3:0] flags,
                          input bit pass, input int n, input logic [31:0] seq,
                          input int lateIdx, input logic [3:0] lateFlags, input int retires);
    applyStimulus(tag, ins, flags, pass, n, seq, lateIdx, lateFlags);
    checkOutput();
    @(negedge clk);
    expRetired = expRetired + retires[15:0];
    checkRetired(tag);
  endtask

  initial begin
    ctl_t got;
    nChecks = 0;
    nFail = 0;
    expRetired = '0;
    reset = 1'b1;
    bus.Instr = 32'h0;
    wbus.Instr = 32'h0;
    driveFlags(4'b0000);
    #2;
    got = sample();
    nChecks++;
    assert (got === '0) else begin
      nFail++;
      $error("[TB] FAIL reset.outputs got=%h expected=0", got);
    end
    checkRetired("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    runInstr("mov",    32'hE3A01005, 4'b0000, 1, 4, 32'h0178,  99, 4'b0000, 1);
    runInstr("ldr",    32'hE5912004, 4'b0000, 1, 5, 32'h01234, 99, 4'b0000, 1);
    runInstr("str",    32'hE5812000, 4'b0000, 1, 4, 32'h0125,  99, 4'b0000, 1);
    runInstr("streq",  32'h05812000, 4'b0000, 0, 4, 32'h0125,  99, 4'b0000, 1);
    runInstr("bl",     32'hEB000002, 4'b0000, 1, 3, 32'h019,   99, 4'b0000, 1);
    runInstr("b",      32'hEA000002, 4'b0000, 1, 3, 32'h019,   99, 4'b0000, 1);
    runInstr("cmp",    32'hE1510002, 4'b0000, 1, 4, 32'h0168,  99, 4'b0000, 1);
    runInstr("illOp",  32'hEC000000, 4'b0000, 1, 2, 32'h01,    99, 4'b0000, 0);
    runInstr("moveq",  32'h03A01005, 4'b1000, 1, 4, 32'h0178,   3, 4'b0000, 1);
    runInstr("movne",  32'h13A01005, 4'b1000, 0, 4, 32'h0178,   3, 4'b0000, 1);
    runInstr("adc",    32'hE0A10002, 4'b0010, 1, 4, 32'h0168,  99, 4'b0000, 1);
    runInstr("movpc",  32'hE1A0F001, 4'b0000, 1, 4, 32'h0168,  99, 4'b0000, 1);
    runInstr("illCnd", 32'hF3A01005, 4'b0000, 1, 2, 32'h01,    99, 4'b0000, 0);
    runInstr("ldrImm", 32'hE7912004, 4'b0000, 1, 2, 32'h01,    99, 4'b0000, 0);
    runInstr("ldrSub", 32'hE5112004, 4'b0000, 1, 5, 32'h01234, 99, 4'b0000, 1);

    applyStimulus("abort", 32'hE5912004, 4'b0000, 1, 4, 32'h0123, 99, 4'b0000);
    checkOutput();
    reset = 1'b1;
    #1;
    got = sample();
    nChecks++;
    assert (got === '0) else begin
      nFail++;
      $error("[TB] FAIL abort.outputs got=%h expected=0", got);
    end
    expRetired = '0;
    checkRetired("abort");
    @(negedge clk);
    reset = 1'b0;
    runInstr("mov2",   32'hE3A01005, 4'b0000, 1, 4, 32'h0178,  99, 4'b0000, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
